gsu_fetch: RTL

Instruction-fetch and cache-fill controller for the GSU core. It sits between the core's decoder and the `gsu_cache` 512-byte dual-port RAM. It serves one opcode byte per request from the cache when the line is valid, fills 16-byte lines from the GSU memory bus on a miss, and bypasses the cache for fetches outside the cache window. It owns the 32 cache-line valid flags and their flush.

---
 rtl/gsu_pkg.sv | 17 +
 rtl/gsu_fetch_if.sv | 31 +++
 rtl/gsu_cache_tags.sv | 36 +++
 rtl/gsu_fetch.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/gsu_pkg.sv
// Shared types and fixed cache geometry for the GSU fetch path.
// 32 lines of 16 bytes form the 512-byte instruction cache.
package gsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HIT_RD,
    FILL,
    DIRECT,
    DONE
  } state_e;

  localparam int CACHE_LINES = 32;
  localparam int LINE_BYTES  = 16;
  localparam int CACHE_BYTES = CACHE_LINES * LINE_BYTES;

endpackage

// File: rtl/gsu_fetch_if.sv
// Fetch request and memory byte-read handshakes of the GSU fetch unit.
// master: the fetch controller; slave: the decoder/memory side.
interface gsu_fetch_if;

  logic        fetch_req;
  logic [7:0]  fetch_bank;
  logic [15:0] fetch_addr;
  logic        fetch_ack;
  logic [7:0]  fetch_data;

  logic        mem_req;
  logic [7:0]  mem_bank;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;

  modport master (
    input  fetch_req, fetch_bank, fetch_addr,
    output fetch_ack, fetch_data,
    output mem_req, mem_bank, mem_addr,
    input  mem_ack, mem_data
  );

  modport slave (
    output fetch_req, fetch_bank, fetch_addr,
    input  fetch_ack, fetch_data,
    input  mem_req, mem_bank, mem_addr,
    output mem_ack, mem_data
  );

endinterface

// File: rtl/gsu_cache_tags.sv
// Per-line valid flags of the instruction cache.
// A clear-all request takes priority over a same-cycle set.
module gsu_cache_tags
  import gsu_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   set_i,
  input  logic [4:0]             set_idx_i,
  input  logic                   clr_i,
  output logic [CACHE_LINES-1:0] valid_o
);

  logic [CACHE_LINES-1:0] valid_q;
  logic [CACHE_LINES-1:0] valid_d;

  always_comb begin
    valid_d = valid_q;
    if (clr_i) begin
      valid_d = '0;
    end else if (set_i) begin
      valid_d[set_idx_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;

endmodule

// File: rtl/gsu_fetch.sv
// GSU opcode fetch: cache hit read, 16-byte line fill on miss,
// and direct memory read for fetches outside the cache window.
module gsu_fetch
  import gsu_pkg::*;
(
  input  logic        clkin,
  input  logic        RESET,
  input  logic        fetch_req,
  input  logic [7:0]  fetch_bank,
  input  logic [15:0] fetch_addr,
  output logic        fetch_ack,
  output logic [7:0]  fetch_data,
  input  logic [15:0] cbr,
  input  logic        flush,
  output logic        mem_req,
  output logic [7:0]  mem_bank,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [8:0]  cache_addra,
  output logic [7:0]  cache_dina,
  output logic        cache_wea,
  output logic [8:0]  cache_addrb,
  input  logic [7:0]  cache_doutb,
  output logic [31:0] cache_valid
);

  state_e state_q, state_d;

  logic [15:0] diff;
  logic        cached;
  logic        hit;
  logic        accept;
  logic        last_byte;
  logic        unused_cbr;

  logic [4:0]  line_q;
  logic [3:0]  off_q;
  logic [3:0]  k_q;
  logic        hit_wait_q;
  logic        flushed_q;
  logic [7:0]  data_q;
  logic [7:0]  bank_q;
  logic [15:0] addr_q;
  logic        wea_q;
  logic [8:0]  addra_q;
  logic [8:0]  addrb_q;
  logic [7:0]  dina_q;

  assign unused_cbr = ^cbr[3:0];
  assign diff   = fetch_addr - {cbr[15:4], 4'h0};
  assign cached = diff < 16'(CACHE_BYTES);
  assign hit    = cached && cache_valid[diff[8:4]];
  assign accept = (state_q == IDLE) && fetch_req;
  assign last_byte = (state_q == FILL) && mem_ack
                  && (k_q == 4'hF);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (fetch_req) begin
          if (!cached)  state_d = DIRECT;
          else if (hit) state_d = HIT_RD;
          else          state_d = FILL;
        end
      end
      HIT_RD: if (hit_wait_q) state_d = DONE;
      FILL:   if (last_byte)  state_d = DONE;
      DIRECT: if (mem_ack)    state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkin or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clkin or negedge RESET) begin
    if (!RESET) begin
      line_q     <= '0;
      off_q      <= '0;
      k_q        <= '0;
      hit_wait_q <= 1'b0;
      flushed_q  <= 1'b0;
      data_q     <= '0;
      bank_q     <= '0;
      addr_q     <= '0;
      wea_q      <= 1'b0;
      addra_q    <= '0;
      addrb_q    <= '0;
      dina_q     <= '0;
    end else begin
      wea_q <= 1'b0;
      // a flush seen anywhere in a fill poisons the line's valid bit
      if (accept)     flushed_q <= flush;
      else if (flush) flushed_q <= 1'b1;
      if (accept) begin
        line_q     <= diff[8:4];
        off_q      <= diff[3:0];
        k_q        <= '0;
        hit_wait_q <= 1'b0;
        bank_q     <= fetch_bank;
        addr_q     <= cached
                    ? fetch_addr - {12'h0, diff[3:0]}
                    : fetch_addr;
        if (hit) addrb_q <= diff[8:0];
      end
      if (state_q == HIT_RD) begin
        hit_wait_q <= 1'b1;
        if (hit_wait_q) data_q <= cache_doutb;
      end
      if ((state_q == FILL) && mem_ack) begin
        wea_q   <= 1'b1;
        addra_q <= {line_q, k_q};
        dina_q  <= mem_data;
        k_q     <= k_q + 4'd1;
        addr_q  <= addr_q + 16'd1;
        if (k_q == off_q) data_q <= mem_data;
      end
      if ((state_q == DIRECT) && mem_ack) begin
        data_q <= mem_data;
      end
    end
  end

  gsu_cache_tags u_tags (
    .clk_i     (clkin),
    .rst_ni    (RESET),
    .set_i     (last_byte && !flushed_q),
    .set_idx_i (line_q),
    .clr_i     (flush),
    .valid_o   (cache_valid)
  );

  assign fetch_ack   = (state_q == DONE);
  assign mem_req     = (state_q == FILL)
                    || (state_q == DIRECT);
  assign fetch_data  = data_q;
  assign mem_bank    = bank_q;
  assign mem_addr    = addr_q;
  assign cache_wea   = wea_q;
  assign cache_addra = addra_q;
  assign cache_dina  = dina_q;
  assign cache_addrb = addrb_q;

endmodule
